// File: rtl/dsp_pkg.sv
// Shared DSP definitions: post-modify opcodes for the auxiliary register file.
package dsp_pkg;

    typedef logic [1:0] ar_op_t;

    localparam ar_op_t AR_OP_NONE = 2'b00;
    localparam ar_op_t AR_OP_INC  = 2'b01;
    localparam ar_op_t AR_OP_DEC  = 2'b10;
    localparam ar_op_t AR_OP_IDX  = 2'b11;

endpackage

// File: rtl/auxreg_cell.sv
// One auxiliary register; a load beats a modify when both are requested.
module auxreg_cell #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         ld_en,
    input  logic [W-1:0] ld_data,
    input  logic         mod_en,
    input  logic [W-1:0] mod_data,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    q <= '0;
        else if (ld_en)  q <= ld_data;
        else if (mod_en) q <= mod_data;
    end

endmodule

// File: rtl/auxreg_file.sv
// Auxiliary register file with ARP and shared post-modify unit for indirect
// data-memory addressing.
module auxreg_file
    import dsp_pkg::*;
#(
    parameter  int W      = 16,
    parameter  int NUM_AR = 8,
    localparam int P      = $clog2(NUM_AR),
    parameter  int A      = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         ld_en,
    input  logic [P-1:0] ld_sel,
    input  logic [W-1:0] ld_data,
    input  logic         mod_en,
    input  ar_op_t       mod_op,
    input  logic         arp_wr,
    input  logic [P-1:0] arp_in,
    output logic [P-1:0] arp,
    output logic [W-1:0] ar_cur,
    output logic [A-1:0] addr,
    output logic         ar_nz
);

    logic [NUM_AR-1:0][W-1:0] ar;
    logic [W-1:0]             mod_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    arp <= '0;
        else if (arp_wr) arp <= arp_in;
    end

    assign ar_cur = ar[arp];
    assign addr   = ar_cur[A-1:0];
    assign ar_nz  = |ar_cur;

    // Single shared arithmetic unit; only the cell selected by the old ARP uses it.
    always_comb begin
        mod_data = ar_cur;
        case (mod_op)
            AR_OP_INC: mod_data = ar_cur + W'(1);
            AR_OP_DEC: mod_data = ar_cur - W'(1);
            AR_OP_IDX: mod_data = ar_cur + ar[0];
            default:   mod_data = ar_cur;
        endcase
    end

    for (genvar i = 0; i < NUM_AR; i++) begin : g_ar
        auxreg_cell #(.W(W)) u_cell (
            .clk      (clk),
            .reset_n  (reset_n),
            .ld_en    (ld_en && (ld_sel == P'(i))),
            .ld_data  (ld_data),
            .mod_en   (mod_en && (mod_op != AR_OP_NONE) && (arp == P'(i))),
            .mod_data (mod_data),
            .q        (ar[i])
        );
    end

endmodule

// File: tb/tb_auxreg_file.sv
// Directed bench for auxreg_file: reset, wrap-around, post-modify with pointer
// switch, load/modify collision, index add and loop countdown.
module tb_auxreg_file;
    import dsp_pkg::*;

    localparam int W = 16;
    localparam int NUM_AR = 8;
    localparam int P = 3;
    localparam int A = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         ld_en;
    logic [P-1:0] ld_sel;
    logic [W-1:0] ld_data;
    logic         mod_en;
    ar_op_t       mod_op;
    logic         arp_wr;
    logic [P-1:0] arp_in;
    logic [P-1:0] arp;
    logic [W-1:0] ar_cur;
    logic [A-1:0] addr;
    logic         ar_nz;

    int compared = 0;
    int mismatched = 0;

    auxreg_file #(.W(W), .NUM_AR(NUM_AR), .A(A)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ld_en   (ld_en),
        .ld_sel  (ld_sel),
        .ld_data (ld_data),
        .mod_en  (mod_en),
        .mod_op  (mod_op),
        .arp_wr  (arp_wr),
        .arp_in  (arp_in),
        .arp     (arp),
        .ar_cur  (ar_cur),
        .addr    (addr),
        .ar_nz   (ar_nz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ld_en = 1'b0; ld_sel = '0; ld_data = '0;
        mod_en = 1'b0; mod_op = AR_OP_NONE;
        arp_wr = 1'b0; arp_in = '0;
    endtask

    // Advance one edge, sample 1 time unit later, then drop all requests.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic load(input logic [P-1:0] sel, input logic [W-1:0] d);
        ld_en = 1'b1; ld_sel = sel; ld_data = d;
    endtask

    task automatic set_arp(input logic [P-1:0] p);
        arp_wr = 1'b1; arp_in = p;
    endtask

    task automatic modify(input ar_op_t op);
        mod_en = 1'b1; mod_op = op;
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        // Load attempt while held in reset must be ignored
        load(3'd3, 16'h1234);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ar3", 32'(dut.ar[3]), 32'h0);
        chk("rst_arp", 32'(arp), 32'h0);
        chk("rst_arcur", 32'(ar_cur), 32'h0);
        chk("rst_addr", 32'(addr), 32'h0);
        chk("rst_nz", 32'(ar_nz), 32'h0);
        idle();
        @(negedge clk);
        reset_n = 1'b1;

        load(3'd3, 16'h1234); set_arp(3'd3); step();
        chk("ld3_arp", 32'(arp), 32'h3);
        chk("ld3_arcur", 32'(ar_cur), 32'h1234);
        chk("ld3_addr", 32'(addr), 32'h34);
        chk("ld3_nz", 32'(ar_nz), 32'h1);

        // Wrap-around
        load(3'd0, 16'hFFFF); set_arp(3'd0); step();
        chk("wrap_ld", 32'(ar_cur), 32'hFFFF);
        modify(AR_OP_INC); step();
        chk("wrap_inc", 32'(ar_cur), 32'h0000);
        chk("wrap_inc_nz", 32'(ar_nz), 32'h0);
        modify(AR_OP_DEC); step();
        chk("wrap_dec", 32'(ar_cur), 32'hFFFF);
        chk("wrap_dec_nz", 32'(ar_nz), 32'h1);

        // Post-modify then pointer switch
        load(3'd1, 16'h0010); set_arp(3'd1); step();
        load(3'd2, 16'h0020); step();
        chk("pm_pre", 32'(ar_cur), 32'h0010);
        modify(AR_OP_INC); set_arp(3'd2); step();
        chk("pm_arp", 32'(arp), 32'h2);
        chk("pm_arcur", 32'(ar_cur), 32'h0020);
        chk("pm_addr", 32'(addr), 32'h20);
        chk("pm_ar1", 32'(dut.ar[1]), 32'h0011);
        chk("pm_ar2", 32'(dut.ar[2]), 32'h0020);
        set_arp(3'd1); step();
        chk("pm_ar1_port", 32'(ar_cur), 32'h0011);

        // Collision: load wins over modify on the same register
        load(3'd4, 16'h0005); set_arp(3'd4); step();
        chk("col_pre", 32'(ar_cur), 32'h0005);
        load(3'd4, 16'h0100); modify(AR_OP_INC); step();
        chk("col_load_wins", 32'(ar_cur), 32'h0100);
        load(3'd0, 16'h0003); step();
        chk("idx_hold", 32'(ar_cur), 32'h0100);
        modify(AR_OP_IDX); step();
        chk("idx_add", 32'(ar_cur), 32'h0103);
        chk("idx_addr", 32'(addr), 32'h03);

        // Index add with arp=0 doubles ar[0]; op NONE is a no-op
        set_arp(3'd0); step();
        chk("dbl_pre", 32'(ar_cur), 32'h0003);
        modify(AR_OP_IDX); step();
        chk("dbl", 32'(ar_cur), 32'h0006);
        modify(AR_OP_NONE); step();
        chk("noop", 32'(ar_cur), 32'h0006);

        // Load to another register alongside a modify: both update
        load(3'd5, 16'h0055); modify(AR_OP_INC); step();
        chk("indep_mod", 32'(ar_cur), 32'h0007);
        chk("indep_ld", 32'(dut.ar[5]), 32'h0055);
        chk("indep_ar4", 32'(dut.ar[4]), 32'h0103);

        // BANZ countdown
        load(3'd7, 16'h0003); set_arp(3'd7); step();
        chk("banz_v3", 32'(ar_cur), 32'h3);
        chk("banz_nz3", 32'(ar_nz), 32'h1);
        modify(AR_OP_DEC); step();
        chk("banz_nz2", 32'(ar_nz), 32'h1);
        modify(AR_OP_DEC); step();
        chk("banz_nz1", 32'(ar_nz), 32'h1);
        modify(AR_OP_DEC); step();
        chk("banz_v0", 32'(ar_cur), 32'h0);
        chk("banz_nz0", 32'(ar_nz), 32'h0);

        // Mid-sequence asynchronous reset
        load(3'd7, 16'h0003); step();
        modify(AR_OP_DEC); step();
        chk("banz2_v2", 32'(ar_cur), 32'h2);
        modify(AR_OP_DEC);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_arp", 32'(arp), 32'h0);
        chk("arst_arcur", 32'(ar_cur), 32'h0);
        chk("arst_nz", 32'(ar_nz), 32'h0);
        chk("arst_ar7", 32'(dut.ar[7]), 32'h0);
        chk("arst_ar0", 32'(dut.ar[0]), 32'h0);
        chk("arst_ar5", 32'(dut.ar[5]), 32'h0);
        load(3'd0, 16'hBEEF); set_arp(3'd5);
        @(posedge clk);
        #1;
        chk("arst_hold_arp", 32'(arp), 32'h0);
        chk("arst_hold_arcur", 32'(ar_cur), 32'h0);
        chk("arst_hold_ar0", 32'(dut.ar[0]), 32'h0);
        idle();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("post_rst_addr", 32'(addr), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/auxreg_file.md
Name: auxreg_file

Overview:
- Parametrised successor to the two-entry auxiliary register pair.
- Holds NUM_AR auxiliary registers of width W, a registered auxiliary register pointer (ARP), and post-modify logic (increment, decrement, add index) for indirect data-memory addressing.
- Drives the data-memory address and a loop-counter non-zero flag to the DSP datapath/control unit.
- Sits between the instruction decoder and the data RAM address mux.

Parameters:
- W, 16, auxiliary register width in bits.
- NUM_AR, 8, number of auxiliary registers; power of two, at least 2.
- P, $clog2(NUM_AR), ARP width (derived; not overridden).
- A, 8, data-memory address width driven on addr; must satisfy A <= W.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ld_en  in  1  load ar[ld_sel] with ld_data at the next edge.
- ld_sel  in  P  index of the register to load.
- ld_data  in  W  load value.
- mod_en  in  1  apply mod_op to ar[arp] at the next edge.
- mod_op  in  2  00 none, 01 increment, 10 decrement, 11 add ar[0] (index).
- arp_wr  in  1  write arp_in into ARP at the next edge.
- arp_in  in  P  new ARP value.
- arp  out  P  current ARP.
- ar_cur  out  W  ar[arp], combinational.
- addr  out  A  ar_cur[A-1:0], combinational.
- ar_nz  out  1  high when ar_cur != 0 (BANZ support).

Behaviour:
- Reset (reset_n low, asynchronous): all ar[i] = 0 and arp = 0. Therefore ar_cur = 0, addr = 0, ar_nz = 0. Outputs stay at these values for as long as reset_n is low, including reset asserted mid-operation. No edge is needed after deassertion.
- Read path:
  - Zero latency: ar_cur, addr and ar_nz follow arp and the register contents combinationally.
  - An edge that changes arp or ar[arp] shows the new values the same cycle, after that edge.
- Update latency: every write takes effect at the rising clk edge after its request.
- Modify: with mod_en=1, ar[arp] <= ar[arp] op operand.
  - Uses the ARP value before this edge.
  - Arithmetic is modulo 2^W. 0xFFFF+1 -> 0x0000 and 0x0000-1 -> 0xFFFF at W=16.
  - op 11 adds the pre-edge value of ar[0]. With arp=0 this doubles ar[0].
  - mod_op=00 with mod_en=1 is a no-op.
- Load: with ld_en=1, ar[ld_sel] <= ld_data.
- Load vs modify, same edge:
  - If ld_sel == pre-edge arp, the load wins and the modify is discarded.
  - Otherwise both registers update independently.
- ARP: with arp_wr=1, arp <= arp_in. A modify on the same edge targets the old arp. This is the "*+, ARn" pattern: post-modify the current register, then switch pointer.
- Any combination of ld_en, mod_en and arp_wr in one cycle is legal. Precedence applies only to the load-vs-modify collision above.
- ld_sel and arp_in are always in range (power-of-two NUM_AR), so there are no illegal indices.
- No X propagation: registers are never written from an unselected source.

Decomposition:
- Shared package dsp_pkg holds:
  - localparams AR_OP_NONE=2'b00, AR_OP_INC=2'b01, AR_OP_DEC=2'b10, AR_OP_IDX=2'b11;
  - a typedef ar_op_t for mod_op.
- One sub-module, auxreg_cell, instantiated NUM_AR times by generate.
  - One W-bit register with async active-low reset.
  - Inputs: load enable/data and modify enable/next-value.
  - Load has priority inside the cell.
- The top level owns ARP, the shared incrementer/decrementer/adder (one instance, operating on ar[arp]), the read mux and ar_nz.

Test Plan:
- Reset check: with reset_n low, write ld_en=1 ld_sel=3 ld_data=0x1234 -> ar[3] stays 0, arp=0, addr=0x00, ar_nz=0. Release reset, then load ar[3]=0x1234 and arp_wr arp_in=3 -> next cycle ar_cur=0x1234, addr=0x34, ar_nz=1.
- Wrap-around:
  - Load ar[0]=0xFFFF, arp=0, mod_en op=01 -> ar_cur=0x0000, ar_nz=0.
  - Then op=10 -> ar_cur=0xFFFF.
- Post-modify plus pointer switch:
  - Setup: ar[1]=0x0010, ar[2]=0x0020, arp=1.
  - Stimulus, single cycle: mod_en op=01 with arp_wr arp_in=2.
  - Expected after the edge: ar[1]=0x0011, arp=2, ar_cur=0x0020, addr=0x20.
- Collision and index add:
  - With arp=4, ar[4]=0x0005: ld_en ld_sel=4 ld_data=0x0100 plus mod_en op=01 -> ar[4]=0x0100 (load wins).
  - Then ar[0]=0x0003, op=11 -> ar[4]=0x0103.
- Loop countdown (BANZ):
  - Load ar[7]=3, arp=7, then mod_en op=10 each cycle.
  - ar_nz sequence: 1,1,1,0 (values 3,2,1,0).
  - Assert reset_n low mid-sequence -> asynchronous clear: arp=0, all ar=0 immediately, before the next edge.
